// File: rtl/mux8_rr_arbiter_if.sv
// ============================================================================
// Module   : mux8_rr_arbiter_if
// Purpose  : Request/grant bundle between requesters and the 8:1 mux arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mux8_rr_arbiter_if;
    logic [7:0] req;
    logic       done;
    logic [2:0] sel;
    logic [7:0] gnt;
    logic       busy;
    logic       timeout;

    // Requester side drives req/done and observes the arbitration result.
    modport master (
        output req,
        output done,
        input  sel,
        input  gnt,
        input  busy,
        input  timeout
    );

    modport slave (
        input  req,
        input  done,
        output sel,
        output gnt,
        output busy,
        output timeout
    );
endinterface

`default_nettype wire

// File: rtl/mux8_rr_arbiter.sv
// ============================================================================
// Module   : mux8_rr_arbiter
// Purpose  : Round-robin arbiter driving the select of an 8:1 mux, with a
//            bounded hold time per grant.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux8_rr_arbiter #(
    parameter int MAX_HOLD = 15
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    mux8_rr_arbiter_if.slave  bus
);

    localparam logic [7:0] c_max_hold = 8'(MAX_HOLD);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t     r_state;
    logic [2:0] r_ptr;
    logic [2:0] r_owner;
    logic [7:0] r_hcnt;
    logic [2:0] r_sel;
    logic [7:0] r_gnt;
    logic       r_busy;
    logic       r_timeout;

    logic [15:0] w_dbl;
    logic [7:0]  w_rot;
    logic [2:0]  w_off;
    logic [2:0]  w_pick;
    logic        w_any;
    logic        w_rel_done;
    logic        w_rel_drop;
    logic        w_rel_max;
    logic        w_release;
    logic        w_tmo_only;

    // Rotate requests so bit 0 is the requester at ptr; the lowest set bit of
    // the rotated vector is then the round-robin winner's offset from ptr.
    assign w_dbl = {bus.req, bus.req} >> r_ptr;
    assign w_rot = w_dbl[7:0];
    assign w_any = |bus.req;

    always_comb begin
        w_off = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = 3'(i);
            end
        end
    end

    assign w_pick     = r_ptr + w_off;
    assign w_rel_done = bus.done;
    assign w_rel_drop = ~bus.req[r_owner];
    assign w_rel_max  = (r_hcnt == c_max_hold);
    assign w_release  = w_rel_done | w_rel_drop | w_rel_max;
    // A forced release coinciding with a voluntary one is not a timeout.
    assign w_tmo_only = w_rel_max & ~w_rel_done & ~w_rel_drop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_ptr     <= 3'd0;
            r_owner   <= 3'd0;
            r_hcnt    <= 8'd0;
            r_sel     <= 3'd0;
            r_gnt     <= 8'd0;
            r_busy    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_state <= ST_GRANT;
                        r_owner <= w_pick;
                        r_sel   <= w_pick;
                        r_gnt   <= 8'd1 << w_pick;
                        r_busy  <= 1'b1;
                        r_hcnt  <= 8'd1;
                    end
                end
                ST_GRANT: begin
                    if (w_release) begin
                        r_state   <= ST_IDLE;
                        r_gnt     <= 8'd0;
                        r_busy    <= 1'b0;
                        r_ptr     <= r_owner + 3'd1;
                        r_hcnt    <= 8'd0;
                        r_timeout <= w_tmo_only;
                    end else begin
                        r_hcnt <= r_hcnt + 8'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.sel     = r_sel;
    assign bus.gnt     = r_gnt;
    assign bus.busy    = r_busy;
    assign bus.timeout = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_mux8_rr_arbiter.sv
// ============================================================================
// Module   : tb_mux8_rr_arbiter
// Purpose  : Directed self-checking bench for mux8_rr_arbiter (MAX_HOLD=4 and 1).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux8_rr_arbiter;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    mux8_rr_arbiter_if bus4 ();
    mux8_rr_arbiter_if bus1 ();

    mux8_rr_arbiter #(.MAX_HOLD(4)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4.slave)
    );

    mux8_rr_arbiter #(.MAX_HOLD(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk4(input string tag, input logic [2:0] sel, input logic [7:0] gnt,
                        input logic busy, input logic tmo);
        chk({tag, ".sel"},  32'(bus4.sel),     32'(sel));
        chk({tag, ".gnt"},  32'(bus4.gnt),     32'(gnt));
        chk({tag, ".busy"}, 32'(bus4.busy),    32'(busy));
        chk({tag, ".tmo"},  32'(bus4.timeout), 32'(tmo));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        bus4.req  = 8'h00;
        bus4.done = 1'b0;
        bus1.req  = 8'h00;
        bus1.done = 1'b0;
        #2;
        chk4("reset", 3'd0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic grant/release with one-cycle latency.
        bus4.req = 8'b0000_0001;
        tick();
        chk4("g0", 3'd0, 8'h01, 1'b1, 1'b0);
        bus4.done = 1'b1;
        tick();
        chk4("g0_rel", 3'd0, 8'h00, 1'b0, 1'b0);
        bus4.done = 1'b0;
        bus4.req  = 8'h00;
        tick();
        chk4("idle_hold", 3'd0, 8'h00, 1'b0, 1'b0);

        // Fairness from ptr=0: grants 0..7,0 each followed by one IDLE cycle.
        do_reset();
        bus4.req  = 8'hFF;
        bus4.done = 1'b1;
        for (int n = 0; n < 9; n++) begin
            tick();
            chk4($sformatf("rr%0d", n), 3'(n % 8), 8'd1 << (n % 8), 1'b1, 1'b0);
            tick();
            chk4($sformatf("rr%0d_idle", n), 3'(n % 8), 8'h00, 1'b0, 1'b0);
        end
        bus4.req  = 8'h00;
        bus4.done = 1'b0;
        tick();

        // Timeout after 4 GRANT cycles (ptr=1, winner 4), then re-grant.
        bus4.req = 8'h10;
        for (int c = 1; c <= 4; c++) begin
            tick();
            chk4($sformatf("hold%0d", c), 3'd4, 8'h10, 1'b1, 1'b0);
        end
        tick();
        chk4("tmo", 3'd4, 8'h00, 1'b0, 1'b1);
        tick();
        chk4("regrant4", 3'd4, 8'h10, 1'b1, 1'b0);

        // done in the 4th GRANT cycle coincides with MAX_HOLD: no timeout.
        tick();
        tick();
        tick();
        chk4("coin_c4", 3'd4, 8'h10, 1'b1, 1'b0);
        bus4.done = 1'b1;
        tick();
        chk4("coin_rel", 3'd4, 8'h00, 1'b0, 1'b0);
        bus4.done = 1'b0;

        // Owner 7 (search from ptr=5), done high in IDLE is ignored.
        bus4.req  = 8'h80;
        bus4.done = 1'b1;
        tick();
        chk4("own7", 3'd7, 8'h80, 1'b1, 1'b0);
        bus4.req = 8'b1000_0100;
        tick();
        chk4("own7_rel", 3'd7, 8'h00, 1'b0, 1'b0);
        bus4.done = 1'b0;
        tick();
        chk4("wrap2", 3'd2, 8'h04, 1'b1, 1'b0);
        // Owner drops its request; other requests must not matter.
        bus4.req = 8'h80;
        tick();
        chk4("drop_rel", 3'd2, 8'h00, 1'b0, 1'b0);
        tick();
        chk4("own7b", 3'd7, 8'h80, 1'b1, 1'b0);

        // Asynchronous reset mid-GRANT, between edges.
        #2;
        rst_n = 1'b0;
        #1;
        chk4("areset", 3'd0, 8'h00, 1'b0, 1'b0);
        #2;
        rst_n = 1'b1;
        bus4.req = 8'h81;
        tick();
        chk4("post_rst_ptr0", 3'd0, 8'h01, 1'b1, 1'b0);
        bus4.req  = 8'h80;
        bus4.done = 1'b1;
        tick();
        bus4.done = 1'b0;
        do_reset();
        bus4.req = 8'h80;
        tick();
        chk4("post_rst7", 3'd7, 8'h80, 1'b1, 1'b0);
        bus4.req = 8'h00;
        tick();

        // MAX_HOLD=1: every grant lasts exactly one cycle, ending in timeout.
        bus1.req = 8'h02;
        tick();
        chk("mh1_gnt",  32'(bus1.gnt),     32'h02);
        tick();
        chk("mh1_rel",  32'(bus1.gnt),     32'h00);
        chk("mh1_tmo",  32'(bus1.timeout), 32'h1);
        tick();
        chk("mh1_regr", 32'(bus1.gnt),     32'h02);
        chk("mh1_tmo0", 32'(bus1.timeout), 32'h0);
        bus1.req = 8'h00;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mux8_rr_arbiter.md
MUX8_RR_ARBITER -- requirements
Module: mux8_rr_arbiter

Interface
REQ-001 The block SHALL have parameter MAX_HOLD, default 15: the maximum number of consecutive GRANT cycles per grant, legal range 1..255.
REQ-002 Port clk, input, 1 bit: the single clock; all state SHALL update on the rising edge.
REQ-003 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 Port req, input, 8 bits: request lines; bit i is the requester on 8:1 mux data input i (a..h = bits 0..7).
REQ-005 Port done, input, 1 bit: release strobe from the current owner; it SHALL be sampled only in GRANT.
REQ-006 Port sel, output, 3 bits: select code for the 8:1 mux; it SHALL equal the owner index.
REQ-007 Port gnt, output, 8 bits: grant vector; it SHALL be one-hot in GRANT and all-zero otherwise.
REQ-008 Port busy, output, 1 bit: high exactly while in GRANT.
REQ-009 Port timeout, output, 1 bit: one-cycle pulse when a grant is forcibly ended by MAX_HOLD.
REQ-010 All outputs SHALL be registered, with no combinational path from input to output.

Function
REQ-011 The FSM SHALL have two states:
- IDLE: no owner.
- GRANT: one owner holds the mux.
REQ-012 Internal state SHALL comprise:
- 3-bit priority pointer ptr.
- 3-bit owner register.
- 8-bit hold counter hcnt.
REQ-013 In IDLE with req != 0 at an edge, the arbiter SHALL choose the first set bit searching ptr, ptr+1, ... ptr+7 (mod 8).
REQ-014 At that same edge the arbiter SHALL:
- enter GRANT;
- load owner and sel with the chosen index;
- set gnt to the one-hot of that index;
- set busy=1 and hcnt=1.
REQ-015 Grant latency SHALL be exactly one cycle: req sampled at edge N gives gnt/sel valid after edge N.
REQ-016 In IDLE with req == 0, state SHALL hold, gnt=0, busy=0, and sel SHALL keep its last value.
REQ-017 In GRANT, the grant SHALL be released at the next edge if any of these hold:
- (a) done=1;
- (b) req[owner]=0;
- (c) hcnt == MAX_HOLD.
REQ-018 Otherwise, in GRANT, hcnt SHALL increment by 1 and all outputs SHALL hold.
REQ-019 On release the arbiter SHALL:
- go to IDLE;
- set gnt=0 and busy=0;
- set ptr = owner+1 mod 8 (7 wraps to 0);
- keep sel unchanged.
REQ-020 After every release there SHALL be at least one IDLE cycle; there are no back-to-back grants.
REQ-021 timeout SHALL be 1 in the first IDLE cycle after a release caused only by (c), and 0 in all other cycles.
REQ-022 If (c) coincides with (a) or (b), the release SHALL count as normal and timeout SHALL stay 0.
REQ-023 req bits other than the owner's SHALL have no effect during GRANT.
REQ-024 done SHALL be ignored in IDLE.
REQ-025 With MAX_HOLD=1, every grant SHALL last exactly one GRANT cycle.
REQ-026 A requester that holds req continuously SHALL be re-granted within 8 arbitration rounds; starvation is not allowed.
REQ-027 hcnt SHALL never exceed MAX_HOLD.

Reset
REQ-028 rst_n low SHALL immediately, without waiting for clk, force:
- state=IDLE;
- sel=0, gnt=0, busy=0, timeout=0;
- ptr=0, owner=0, hcnt=0.
REQ-029 Reset asserted during GRANT SHALL drop the grant immediately, with no timeout pulse.
REQ-030 After reset, arbitration SHALL restart with ptr=0.
REQ-031 The first arbitration SHALL occur at the first rising edge with rst_n high.

Verification
REQ-032 Reset then req=8'b0000_0001 -> after one edge sel=0, gnt=8'h01, busy=1; done pulsed -> next cycle gnt=0, busy=0, timeout=0, sel stays 0.
REQ-033 Fairness: req=8'hFF held, done pulsed every GRANT cycle -> owners in order 0,1,...,7,0, each grant separated by exactly one IDLE cycle.
REQ-034 Timeout: MAX_HOLD=4, req=8'h10 held, done=0 -> gnt=8'h10 for exactly 4 cycles, then gnt=0 with timeout=1 for one cycle, then re-grant to 4.
REQ-035 Coincidence: MAX_HOLD=4, done=1 in the 4th GRANT cycle -> release with timeout=0.
REQ-036 Wrap and skip: owner 7 released with req=8'b1000_0100 -> next owner 2; req[owner] dropped mid-grant -> release at next edge.
REQ-037 Async reset: rst_n pulled low mid-GRANT between clock edges -> gnt=0, busy=0, sel=0 immediately; after release, req=8'h80 -> owner 7 (search from ptr=0).
